turn_mutex_arbiter: RTL and testbench

//  Hardware mutex arbiter granting one shared resource among HIPROC+1 requesters.

---
 rtl/turn_mutex_arbiter.sv | 147 ++++++++++++++
 tb/tb_turn_mutex_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/turn_mutex_arbiter.sv
// Turn-pointer mutex arbiter: one shared resource among HIPROC+1 requesters, fair cyclic hand-off.
// Optional forced revoke of long-held grants when TMA_TIMEOUT_EN is defined.
module turn_mutex_arbiter #(
    parameter int HIPROC  = 2,
    parameter int SELMSB  = 1,
    parameter int MAXHOLD = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [HIPROC:0]   req,
    input  logic [HIPROC:0]   rel,
    output logic [HIPROC:0]   grant,
    output logic [SELMSB:0]   owner,
    output logic [SELMSB:0]   turn,
    output logic              busy
`ifdef TMA_TIMEOUT_EN
    ,
    output logic              timeout
`endif
);

    localparam int IW = SELMSB + 1;
    localparam logic [IW-1:0] LAST = IW'(HIPROC);

    // Handshake: req is a level held while wanting the resource; rel is a
    // one-cycle pulse honoured only from the current owner while granted.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SCAN    = 2'd1,
        S_GRANT   = 2'd2,
        S_HANDOFF = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   j_q, j_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   turn_q, turn_d;
    logic [HIPROC:0] grant_q, grant_d;
    logic            drop;

`ifdef TMA_TIMEOUT_EN
    localparam int HW = $clog2(MAXHOLD + 1);
    logic [HW-1:0] hold_q, hold_d;
    logic          timeout_q, timeout_d;
`endif

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
        return (i == LAST) ? '0 : i + IW'(1);
    endfunction

    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        owner_d = owner_q;
        turn_d  = turn_q;
        grant_d = grant_q;
        drop    = 1'b0;
`ifdef TMA_TIMEOUT_EN
        hold_d    = hold_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    state_d = S_SCAN;
                    j_d     = turn_q;
                end
            end
            S_SCAN: begin
                if (req == '0) begin
                    state_d = S_IDLE;
                end else if (req[j_q]) begin
                    state_d    = S_GRANT;
                    owner_d    = j_q;
                    grant_d    = '0;
                    grant_d[j_q] = 1'b1;
`ifdef TMA_TIMEOUT_EN
                    hold_d     = '0;
`endif
                end else begin
                    j_d = wrap_inc(j_q);
                end
            end
            S_GRANT: begin
                drop = rel[owner_q] | ~req[owner_q];
`ifdef TMA_TIMEOUT_EN
                hold_d = hold_q + HW'(1);
                if (!drop && hold_q == HW'(MAXHOLD)) begin
                    drop      = 1'b1;
                    timeout_d = 1'b1;
                end
`endif
                if (drop) begin
                    state_d = S_HANDOFF;
                    grant_d = '0;
                    j_d     = wrap_inc(owner_q);
                end
            end
            S_HANDOFF: begin
                // Turn lands on the next waiting requester, or back on the owner if none.
                if (j_q == owner_q) begin
                    turn_d  = owner_q;
                    state_d = S_IDLE;
                end else if (req[j_q]) begin
                    turn_d  = j_q;
                    state_d = S_IDLE;
                end else begin
                    j_d = wrap_inc(j_q);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            j_q     <= '0;
            owner_q <= '0;
            turn_q  <= '0;
            grant_q <= '0;
`ifdef TMA_TIMEOUT_EN
            hold_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            owner_q <= owner_d;
            turn_q  <= turn_d;
            grant_q <= grant_d;
`ifdef TMA_TIMEOUT_EN
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign grant = grant_q;
    assign owner = owner_q;
    assign turn  = turn_q;
    assign busy  = (state_q != S_IDLE);
`ifdef TMA_TIMEOUT_EN
    assign timeout = timeout_q;
`endif

endmodule

// File: tb/tb_turn_mutex_arbiter.sv
// Bench for turn_mutex_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_turn_mutex_arbiter;

    localparam int HIPROC  = 2;
    localparam int SELMSB  = 1;
    localparam int MAXHOLD = 15;
    localparam int N       = HIPROC + 1;

    localparam int P_IDLE = 0, P_SCAN = 1, P_GRANT = 2, P_HANDOFF = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  rel = '0;
    logic [N-1:0]  grant;
    logic [SELMSB:0] owner;
    logic [SELMSB:0] turn;
    logic          busy;
`ifdef TMA_TIMEOUT_EN
    logic          timeout;
`endif

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    turn_mutex_arbiter #(.HIPROC(HIPROC), .SELMSB(SELMSB), .MAXHOLD(MAXHOLD)) dut (
        .clock(clk),
        .reset(rst),
        .req(req),
        .rel(rel),
        .grant(grant),
        .owner(owner),
        .turn(turn),
        .busy(busy)
`ifdef TMA_TIMEOUT_EN
        ,
        .timeout(timeout)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int           m_phase = P_IDLE;
    int           m_j = 0, m_owner = 0, m_turn = 0, m_hold = 0;
    logic [N-1:0] m_grant = '0;
    logic         m_timeout = 1'b0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_phase = P_IDLE; m_j = 0; m_owner = 0; m_turn = 0;
                m_hold = 0; m_grant = '0; m_timeout = 1'b0;
            end else begin
                logic [N-1:0] r, l;
                bit released;
                r = req;
                l = rel;
                m_timeout = 1'b0;
                case (m_phase)
                    P_IDLE: if (r != 0) begin m_phase = P_SCAN; m_j = m_turn; end
                    P_SCAN: begin
                        if (r == 0) m_phase = P_IDLE;
                        else if (r[m_j]) begin
                            m_phase = P_GRANT; m_owner = m_j;
                            m_grant = N'(1) << m_j; m_hold = 0;
                        end else m_j = (m_j + 1) % N;
                    end
                    P_GRANT: begin
                        released = l[m_owner] || !r[m_owner];
`ifdef TMA_TIMEOUT_EN
                        if (!released && m_hold == MAXHOLD) begin
                            released = 1'b1; m_timeout = 1'b1;
                        end
`endif
                        if (released) begin
                            m_phase = P_HANDOFF; m_grant = '0;
                            m_j = (m_owner + 1) % N;
                        end else m_hold = m_hold + 1;
                    end
                    default: begin
                        if (m_j == m_owner) begin m_turn = m_owner; m_phase = P_IDLE; end
                        else if (r[m_j]) begin m_turn = m_j; m_phase = P_IDLE; end
                        else m_j = (m_j + 1) % N;
                    end
                endcase
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_grant", 32'(grant), 32'(m_grant));
            chk("model_owner", 32'(owner), 32'(m_owner));
            chk("model_turn",  32'(turn),  32'(m_turn));
            chk("model_busy",  32'(busy),  32'(m_phase != P_IDLE));
            chk("onehot",      32'($countones(grant) <= 1), 32'd1);
`ifdef TMA_TIMEOUT_EN
            chk("model_timeout", 32'(timeout), 32'(m_timeout));
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = '0; rel = '0; rst = 1'b1;
        step(); step();
        rst = 1'b0;
    endtask

    function automatic int grant_idx(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return -1;
    endfunction

    int exp_ord[4] = '{0, 1, 2, 0};

    initial begin
        rst = 1'b1;
        step();
        cmp_en = 1'b1;
        do_reset();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy",  32'(busy), 0);

        // Single requester, then release with req dropped.
        req = 3'b001; step();
        chk("t1_e0_grant", 32'(grant), 0);
        chk("t1_e0_busy",  32'(busy), 1);
        step();
        chk("t1_grant", 32'(grant), 32'b001);
        chk("t1_owner", 32'(owner), 0);
        rel = 3'b001; req = 3'b000; step(); rel = '0;
        chk("t1_rel_grant", 32'(grant), 0);
        repeat (3) step();
        chk("t1_idle_busy", 32'(busy), 0);
        chk("t1_idle_turn", 32'(turn), 0);

        // Index 0 skipped, then hand-off to waiting requester 2.
        req = 3'b110; step(); step();
        chk("t2_e1_grant", 32'(grant), 0);
        step();
        chk("t2_grant", 32'(grant), 32'b010);
        chk("t2_owner", 32'(owner), 1);
        rel = 3'b010; req = 3'b100; step(); rel = '0;
        chk("t2_handoff_grant", 32'(grant), 0);
        step();
        chk("t2_turn", 32'(turn), 2);
        chk("t2_turn_busy", 32'(busy), 0);
        step(); step();
        chk("t2_next_grant", 32'(grant), 32'b100);
        chk("t2_next_owner", 32'(owner), 2);

        // All requesting: strict round-robin order.
        do_reset();
        req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            int w = 0;
            while (grant == 0 && w < 20) begin step(); w++; end
            chk("t3_wait_bound", 32'(w < 20), 1);
            chk("t3_order", 32'(grant_idx(grant)), 32'(exp_ord[k]));
            rel = grant; step(); rel = '0;
        end

        // Foreign releases ignored; dropping own req releases.
        do_reset();
        req = 3'b010; step(); step(); step();
        chk("t4_grant", 32'(grant), 32'b010);
        req = 3'b111; rel = 3'b101; step(); rel = '0;
        chk("t4_foreign_rel", 32'(grant), 32'b010);
        step();
        chk("t4_still", 32'(grant), 32'b010);
        req = 3'b101; step();
        chk("t4_drop_grant", 32'(grant), 0);
        chk("t4_drop_busy",  32'(busy), 1);
        step();
        chk("t4_turn", 32'(turn), 2);
        step(); step();
        chk("t4_grant2", 32'(grant), 32'b100);

        // Asynchronous reset mid-grant.
        #2 rst = 1'b1;
        #1;
        chk("t5_async_grant", 32'(grant), 0);
        chk("t5_async_turn",  32'(turn), 0);
        chk("t5_async_owner", 32'(owner), 0);
        chk("t5_async_busy",  32'(busy), 0);
        #3 rst = 1'b0;
        req = 3'b100;
        step(); step(); step();
        chk("t5_e2_grant", 32'(grant), 0);
        step();
        chk("t5_grant", 32'(grant), 32'b100);

        // Never-releasing owner.
        do_reset();
        req = 3'b001; step(); step();
        chk("t6_grant", 32'(grant), 32'b001);
`ifdef TMA_TIMEOUT_EN
        repeat (15) step();
        chk("t6_pre_grant", 32'(grant), 32'b001);
        chk("t6_pre_timeout", 32'(timeout), 0);
        step();
        chk("t6_revoke_grant", 32'(grant), 0);
        chk("t6_timeout", 32'(timeout), 1);
        step();
        chk("t6_timeout_pulse", 32'(timeout), 0);
`else
        repeat (100) step();
        chk("t6_held_grant", 32'(grant), 32'b001);
        chk("t6_held_busy",  32'(busy), 1);
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
            rel = ($urandom_range(0, 2) == 0) ? N'($urandom_range(0, (1 << N) - 1)) : '0;
            step();
        end
        req = '0; rel = '0;
        repeat (8) step();
        cmp_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
